// File: rtl/draw_pkg.sv
// Shared types for the draw command schedulers: FSM states, the command
// record and the two-requester round-robin pick.
package draw_pkg;

  localparam int CMD_CORDW = 16;
  localparam int CMD_DATAW = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DRAIN
  } draw_state_t;

  // Coordinates are two's complement; kept as plain bit fields so the
  // record packs cleanly into FIFOs and register banks.
  typedef struct packed {
    logic [CMD_CORDW-1:0] x0;
    logic [CMD_CORDW-1:0] y0;
    logic [CMD_CORDW-1:0] x1;
    logic [CMD_CORDW-1:0] y1;
    logic [CMD_DATAW-1:0] color;
  } draw_cmd_t;

  // One-hot grant for two requesters; on a tie the one that did not win
  // last time is chosen.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid,
                                         input logic       last_grant);
    logic [1:0] g;
    g = valid;
    if (valid == 2'b11) g = last_grant ? 2'b01 : 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/draw_pix_addr.sv
// Two-stage pixel pipeline: stage1 clips and forms y*stride, stage2 adds
// base and x and presents a VRAM write that is held until acknowledged.
module draw_pix_addr #(
  parameter int CORDW = 16,
  parameter int ADDRW = 16,
  parameter int DATAW = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pix_load,
  input  logic signed [CORDW-1:0] pix_x,
  input  logic signed [CORDW-1:0] pix_y,
  input  logic        [ADDRW-1:0] base,
  input  logic        [ADDRW-1:0] stride,
  input  logic signed [CORDW-1:0] clip_w,
  input  logic signed [CORDW-1:0] clip_h,
  input  logic        [DATAW-1:0] color,
  input  logic                    flush,
  input  logic                    vram_ack,
  output logic                    s1_valid,
  output logic                    s1_adv,
  output logic                    vram_wr,
  output logic        [ADDRW-1:0] vram_addr,
  output logic        [DATAW-1:0] vram_data
);

  logic             s1_vis_q;
  logic [ADDRW-1:0] s1_x_q, s1_prod_q;
  logic [ADDRW-1:0] x_ext, y_ext, prod_d;
  logic             vis_d, s2_free;

  // Sign-extending casts: only the low ADDRW bits of the product matter,
  // and those are identical for signed and unsigned operands.
  assign x_ext  = ADDRW'(pix_x);
  assign y_ext  = ADDRW'(pix_y);
  assign prod_d = y_ext * stride;
  assign vis_d  = !pix_x[CORDW-1] && !pix_y[CORDW-1] &&
                  (pix_x < clip_w) && (pix_y < clip_h);

  assign s2_free   = !vram_wr || vram_ack;
  assign s1_adv    = !s1_valid || s2_free;
  assign vram_data = color;

  // Stage1: capture the pixel, its visibility and the row offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_vis_q  <= 1'b0;
      s1_x_q    <= '0;
      s1_prod_q <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid  <= pix_load;
      s1_vis_q  <= vis_d;
      s1_x_q    <= x_ext;
      s1_prod_q <= prod_d;
    end
  end

  // Stage2: form the word address; a pending write only moves on ack.
  // A flushed stage1 pixel is dropped rather than promoted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vram_wr   <= 1'b0;
      vram_addr <= '0;
    end else if (s2_free) begin
      vram_wr   <= s1_valid && s1_vis_q && !flush;
      vram_addr <= base + s1_prod_q + s1_x_q;
    end
  end

endmodule

// File: rtl/draw_fill_scheduler.sv
// Arbitrates rectangle-fill commands from two requesters and sequences the
// shared fill engine; pixels are clipped and written through draw_pix_addr.
module draw_fill_scheduler
  import draw_pkg::*;
#(
  parameter int CORDW = 16,
  parameter int ADDRW = 16,
  parameter int DATAW = 16
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [2*CORDW-1:0]      req_x0_i,
  input  logic [2*CORDW-1:0]      req_y0_i,
  input  logic [2*CORDW-1:0]      req_x1_i,
  input  logic [2*CORDW-1:0]      req_y1_i,
  input  logic [2*DATAW-1:0]      req_color_i,
  input  logic [ADDRW-1:0]        base_addr_i,
  input  logic [ADDRW-1:0]        stride_i,
  input  logic signed [CORDW-1:0] clip_w_i,
  input  logic signed [CORDW-1:0] clip_h_i,
  input  logic                    abort_i,
  output logic                    eng_start_o,
  output logic signed [CORDW-1:0] eng_x0_o,
  output logic signed [CORDW-1:0] eng_y0_o,
  output logic signed [CORDW-1:0] eng_x1_o,
  output logic signed [CORDW-1:0] eng_y1_o,
  output logic                    eng_ena_o,
  output logic                    eng_abort_o,
  input  logic                    eng_pix_i,
  input  logic signed [CORDW-1:0] eng_x_i,
  input  logic signed [CORDW-1:0] eng_y_i,
  input  logic                    eng_done_i,
  output logic                    vram_wr_o,
  output logic [ADDRW-1:0]        vram_addr_o,
  output logic [DATAW-1:0]        vram_data_o,
  input  logic                    vram_ack_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    aborted_o
);

  draw_state_t             state_q, state_d;
  logic                    last_grant_q, aborted_q;
  logic [1:0]              req_ready_q, grant;
  logic                    pick, flush, set_aborted, cmd_done;
  logic                    s1_valid, s1_adv;
  logic signed [CORDW-1:0] clip_w_q, clip_h_q;
  logic [DATAW-1:0]        color_q;
  logic [ADDRW-1:0]        base_q, stride_q;

  assign grant = (state_q == ST_IDLE) ? rr_pick(req_valid_i, last_grant_q) : 2'b00;
  assign pick  = grant[1];

  assign req_ready_o = req_ready_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign eng_start_o = (state_q == ST_START);
  assign eng_ena_o   = (state_q == ST_RUN) && s1_adv;
  assign done_o      = cmd_done;
  // The abort flag is shown from the done pulse until the next accept.
  assign aborted_o   = aborted_q && (cmd_done || state_q == ST_IDLE);

  // Next-state decode; abort takes priority over engine completion.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    flush       = 1'b0;
    eng_abort_o = 1'b0;
    set_aborted = 1'b0;
    cmd_done    = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (|grant) state_d = ST_START;
      ST_START, ST_RUN: begin
        if (abort_i) begin
          eng_abort_o = 1'b1;
          flush       = 1'b1;
          set_aborted = 1'b1;
          state_d     = ST_DRAIN;
        end else if (state_q == ST_START) begin
          state_d = ST_RUN;
        end else if (eng_done_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        flush = abort_i;
        if (!s1_valid && !vram_wr_o) begin
          cmd_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Control state: FSM, round-robin history, accept pulse, abort flag.
  always_ff @(posedge clk or negedge reset_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      req_ready_q  <= 2'b00;
      aborted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= grant;
      if (|grant) begin
        last_grant_q <= pick;
        aborted_q    <= 1'b0;
      end else if (set_aborted) begin
        aborted_q <= 1'b1;
      end
    end
  end

  // Command latch: captured from the winning requester on accept.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      eng_x0_o <= '0;
      eng_y0_o <= '0;
      eng_x1_o <= '0;
      eng_y1_o <= '0;
      color_q  <= '0;
      base_q   <= '0;
      stride_q <= '0;
      clip_w_q <= '0;
      clip_h_q <= '0;
    end else if (|grant) begin
      eng_x0_o <= pick ? req_x0_i[CORDW +: CORDW] : req_x0_i[0 +: CORDW];
      eng_y0_o <= pick ? req_y0_i[CORDW +: CORDW] : req_y0_i[0 +: CORDW];
      eng_x1_o <= pick ? req_x1_i[CORDW +: CORDW] : req_x1_i[0 +: CORDW];
      eng_y1_o <= pick ? req_y1_i[CORDW +: CORDW] : req_y1_i[0 +: CORDW];
      color_q  <= pick ? req_color_i[DATAW +: DATAW] : req_color_i[0 +: DATAW];
      base_q   <= base_addr_i;
      stride_q <= stride_i;
      clip_w_q <= clip_w_i;
      clip_h_q <= clip_h_i;
    end
  end

  draw_pix_addr #(
    .CORDW(CORDW),
    .ADDRW(ADDRW),
    .DATAW(DATAW)
  ) u_pix_addr (
    .clk      (clk),
    .rst_n    (reset_n_i),
    .pix_load (eng_pix_i && eng_ena_o),
    .pix_x    (eng_x_i),
    .pix_y    (eng_y_i),
    .base     (base_q),
    .stride   (stride_q),
    .clip_w   (clip_w_q),
    .clip_h   (clip_h_q),
    .color    (color_q),
    .flush    (flush),
    .vram_ack (vram_ack_i),
    .s1_valid (s1_valid),
    .s1_adv   (s1_adv),
    .vram_wr  (vram_wr_o),
    .vram_addr(vram_addr_o),
    .vram_data(vram_data_o)
  );

endmodule

// File: tb/tb_draw_fill_scheduler.sv
// Directed bench for draw_fill_scheduler with a behavioural rectangle engine
// and a VRAM write monitor.
module tb_draw_fill_scheduler;

  localparam int CORDW = 16;
  localparam int ADDRW = 16;
  localparam int DATAW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset_n_i;
  logic [1:0]              req_valid_i, req_ready_o;
  logic [2*CORDW-1:0]      req_x0_i, req_y0_i, req_x1_i, req_y1_i;
  logic [2*DATAW-1:0]      req_color_i;
  logic [ADDRW-1:0]        base_addr_i, stride_i;
  logic signed [CORDW-1:0] clip_w_i, clip_h_i;
  logic                    abort_i;
  logic                    eng_start_o, eng_ena_o, eng_abort_o;
  logic signed [CORDW-1:0] eng_x0_o, eng_y0_o, eng_x1_o, eng_y1_o;
  logic                    eng_pix_i, eng_done_i;
  logic signed [CORDW-1:0] eng_x_i, eng_y_i;
  logic                    vram_wr_o, vram_ack_i;
  logic [ADDRW-1:0]        vram_addr_o;
  logic [DATAW-1:0]        vram_data_o;
  logic                    busy_o, done_o, aborted_o;

  draw_fill_scheduler #(.CORDW(CORDW), .ADDRW(ADDRW), .DATAW(DATAW)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_x0_i(req_x0_i), .req_y0_i(req_y0_i), .req_x1_i(req_x1_i), .req_y1_i(req_y1_i),
    .req_color_i(req_color_i), .base_addr_i(base_addr_i), .stride_i(stride_i),
    .clip_w_i(clip_w_i), .clip_h_i(clip_h_i), .abort_i(abort_i),
    .eng_start_o(eng_start_o), .eng_x0_o(eng_x0_o), .eng_y0_o(eng_y0_o),
    .eng_x1_o(eng_x1_o), .eng_y1_o(eng_y1_o), .eng_ena_o(eng_ena_o),
    .eng_abort_o(eng_abort_o), .eng_pix_i(eng_pix_i), .eng_x_i(eng_x_i),
    .eng_y_i(eng_y_i), .eng_done_i(eng_done_i), .vram_wr_o(vram_wr_o),
    .vram_addr_o(vram_addr_o), .vram_data_o(vram_data_o), .vram_ack_i(vram_ack_i),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o)
  );

  // Behavioural fill engine: row-major walk, one pixel per enabled cycle,
  // done one cycle after the last pixel.
  logic eng_active;
  assign eng_pix_i = eng_active && eng_ena_o;

  always @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      eng_active <= 1'b0;
      eng_done_i <= 1'b0;
      eng_x_i    <= '0;
      eng_y_i    <= '0;
    end else begin
      eng_done_i <= 1'b0;
      if (eng_abort_o) begin
        eng_active <= 1'b0;
      end else if (eng_start_o) begin
        eng_active <= 1'b1;
        eng_x_i    <= eng_x0_o;
        eng_y_i    <= eng_y0_o;
      end else if (eng_pix_i) begin
        if (eng_x_i == eng_x1_o) begin
          eng_x_i <= eng_x0_o;
          if (eng_y_i == eng_y1_o) begin
            eng_active <= 1'b0;
            eng_done_i <= 1'b1;
          end else begin
            eng_y_i <= eng_y_i + 1'b1;
          end
        end else begin
          eng_x_i <= eng_x_i + 1'b1;
        end
      end
    end
  end

  // Monitor on the falling edge: accepted writes, pixels, pulses, grants,
  // and stability of a stalled write.
  logic [ADDRW-1:0] wr_addr[$];
  logic [DATAW-1:0] wr_data[$];
  int               grants[$];
  int               pix_cnt, abort_cnt, done_cnt, onehot_err, stall_err;
  logic             stall_prev;
  logic [ADDRW-1:0] stall_addr;
  logic [DATAW-1:0] stall_data;

  initial begin
    pix_cnt = 0; abort_cnt = 0; done_cnt = 0; onehot_err = 0; stall_err = 0;
    stall_prev = 1'b0; stall_addr = '0; stall_data = '0;
  end

  always @(negedge clk) begin
    if (vram_wr_o && vram_ack_i) begin
      wr_addr.push_back(vram_addr_o);
      wr_data.push_back(vram_data_o);
    end
    if (eng_pix_i) pix_cnt++;
    if (eng_abort_o) abort_cnt++;
    if (done_o) done_cnt++;
    if (req_ready_o != 2'b00) begin
      grants.push_back(int'(req_ready_o[1]));
      if (req_ready_o == 2'b11) onehot_err++;
    end
    if (stall_prev && (!vram_wr_o || vram_addr_o != stall_addr || vram_data_o != stall_data))
      stall_err++;
    stall_prev = vram_wr_o && !vram_ack_i;
    stall_addr = vram_addr_o;
    stall_data = vram_data_o;
  end

  int   tests = 0;
  int   fails = 0;
  logic done_aborted;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    grants.delete();
    pix_cnt = 0; abort_cnt = 0; done_cnt = 0; onehot_err = 0;
  endtask

  task automatic set_req(input int r, input logic [15:0] x0, y0, x1, y1, c);
    req_x0_i[r*CORDW +: CORDW]    = x0;
    req_y0_i[r*CORDW +: CORDW]    = y0;
    req_x1_i[r*CORDW +: CORDW]    = x1;
    req_y1_i[r*CORDW +: CORDW]    = y1;
    req_color_i[r*DATAW +: DATAW] = c;
  endtask

  // Present a command and hold it until the accept pulse (bounded).
  task automatic issue(input int r, input logic [15:0] x0, y0, x1, y1, c);
    bit got;
    got = 1'b0;
    set_req(r, x0, y0, x1, y1, c);
    req_valid_i[r] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (req_ready_o[r]) begin got = 1'b1; break; end
    end
    req_valid_i[r] = 1'b0;
    check($sformatf("grant_r%0d", r), int'(got), 1);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done_o) begin seen = 1'b1; done_aborted = aborted_o; break; end
    end
    check({tag, "_done_seen"}, int'(seen), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, int'({req_ready_o, eng_start_o, eng_ena_o, eng_abort_o,
                                vram_wr_o, busy_o, done_o, aborted_o}), 0);
    check({tag, "_vram"}, int'({vram_addr_o, vram_data_o}), 0);
    check({tag, "_verts"}, int'(|{eng_x0_o, eng_y0_o, eng_x1_o, eng_y1_o}), 0);
  endtask

  logic [15:0] exp_t1[6];
  int          ena_hi, wr_lo;
  bit          reached;

  initial begin
    reset_n_i = 1'b0; req_valid_i = 2'b00; abort_i = 1'b0; vram_ack_i = 1'b0;
    req_x0_i = '0; req_y0_i = '0; req_x1_i = '0; req_y1_i = '0; req_color_i = '0;
    base_addr_i = 16'h1000; stride_i = 16'd80; clip_w_i = 16'sd320; clip_h_i = 16'sd240;
    done_aborted = 1'b0;
    exp_t1 = '{16'h1052, 16'h1053, 16'h1054, 16'h10A2, 16'h10A3, 16'h10A4};

    // Reset state
    @(negedge clk);
    check_all_zero("reset");
    vram_ack_i = 1'b1;
    @(posedge clk); #1 reset_n_i = 1'b1;
    @(posedge clk); #1;

    // Basic rectangle (2,1)-(4,2) from requester 0
    clear_log();
    issue(0, 16'd2, 16'd1, 16'd4, 16'd2, 16'hABCD);
    check("t1_start_pulse", int'(eng_start_o), 1);
    check("t1_busy", int'(busy_o), 1);
    wait_done("t1");
    check("t1_aborted", int'(done_aborted), 0);
    @(posedge clk); #1;
    check("t1_idle_busy", int'(busy_o), 0);
    check("t1_wr_count", wr_addr.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("t1_addr%0d", i), int'(wr_addr[i]), int'(exp_t1[i]));
        check($sformatf("t1_data%0d", i), int'(wr_data[i]), 'hABCD);
      end
    end
    check("t1_done_cnt", done_cnt, 1);

    // Round-robin after a fresh reset: both always valid, one-pixel rects
    reset_n_i = 1'b0;
    @(posedge clk); #1 reset_n_i = 1'b1;
    clear_log();
    set_req(0, 16'd5, 16'd5, 16'd5, 16'd5, 16'h1111);
    set_req(1, 16'd7, 16'd3, 16'd7, 16'd3, 16'h2222);
    req_valid_i = 2'b11;
    wait_done("t2a");
    wait_done("t2b");
    wait_done("t2c");
    req_valid_i = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t2_grant_cnt", grants.size(), 3);
    if (grants.size() == 3) begin
      check("t2_grant0", grants[0], 0);
      check("t2_grant1", grants[1], 1);
      check("t2_grant2", grants[2], 0);
    end
    check("t2_onehot", onehot_err, 0);
    check("t2_wr_count", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      check("t2_addr0", int'(wr_addr[0]), 'h1195);
      check("t2_addr1", int'(wr_addr[1]), 'h10F7);
      check("t2_data1", int'(wr_data[1]), 'h2222);
      check("t2_addr2", int'(wr_addr[2]), 'h1195);
    end

    // Left-edge clipping: (-1,0)-(1,0)
    clear_log();
    issue(0, 16'hFFFF, 16'd0, 16'd1, 16'd0, 16'h0F0F);
    wait_done("t3");
    @(posedge clk); #1;
    check("t3_wr_count", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("t3_addr0", int'(wr_addr[0]), 'h1000);
      check("t3_addr1", int'(wr_addr[1]), 'h1001);
    end
    check("t3_pix_consumed", pix_cnt, 3);

    // Back-pressure: ack low for 5 cycles mid-rectangle
    clear_log();
    issue(0, 16'd0, 16'd0, 16'd7, 16'd0, 16'h7E7E);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_addr.size() >= 2) begin reached = 1'b1; break; end
    end
    check("t4_two_writes", int'(reached), 1);
    @(posedge clk); #1 vram_ack_i = 1'b0;
    ena_hi = 0; wr_lo = 0;
    repeat (5) begin
      @(negedge clk);
      if (eng_ena_o) ena_hi++;
      if (!vram_wr_o) wr_lo++;
    end
    @(posedge clk); #1 vram_ack_i = 1'b1;
    check("t4_ena_stalled", ena_hi, 0);
    check("t4_wr_held", wr_lo, 0);
    wait_done("t4");
    @(posedge clk); #1;
    check("t4_wr_count", wr_addr.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < wr_addr.size()) check($sformatf("t4_addr%0d", i), int'(wr_addr[i]), 'h1000 + i);
    check("t4_stable", stall_err, 0);

    // Abort in RUN with a write pending
    clear_log();
    vram_ack_i = 1'b0;
    issue(0, 16'd0, 16'd0, 16'd9, 16'd0, 16'h3C3C);
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vram_wr_o) begin reached = 1'b1; break; end
    end
    check("t5_wr_pending", int'(reached), 1);
    @(posedge clk); #1 abort_i = 1'b1;
    @(negedge clk);
    check("t5_eng_abort", int'(eng_abort_o), 1);
    @(posedge clk); #1 abort_i = 1'b0;
    @(negedge clk);
    check("t5_wr_still", int'(vram_wr_o), 1);
    @(posedge clk); #1 vram_ack_i = 1'b1;
    wait_done("t5");
    check("t5_aborted_at_done", int'(done_aborted), 1);
    @(posedge clk); #1;
    check("t5_aborted_held", int'(aborted_o), 1);
    check("t5_wr_count", wr_addr.size(), 1);
    if (wr_addr.size() == 1) check("t5_addr", int'(wr_addr[0]), 'h1000);
    check("t5_abort_cnt", abort_cnt, 1);
    check("t5_stable", stall_err, 0);

    // Asynchronous reset in the middle of a command
    clear_log();
    issue(0, 16'd0, 16'd0, 16'd9, 16'd9, 16'h6666);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_addr.size() >= 3) begin reached = 1'b1; break; end
    end
    check("t6_running", int'(reached), 1);
    @(posedge clk); #3 reset_n_i = 1'b0;
    #1 check_all_zero("t6_async");
    @(posedge clk); #1 reset_n_i = 1'b1;
    clear_log();
    issue(1, 16'd3, 16'd2, 16'd3, 16'd2, 16'h5555);
    wait_done("t6");
    check("t6_aborted", int'(done_aborted), 0);
    @(posedge clk); #1;
    check("t6_wr_count", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("t6_addr", int'(wr_addr[0]), 'h10A3);
      check("t6_data", int'(wr_data[0]), 'h5555);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/draw_fill_scheduler.md
Name: draw_fill_scheduler

Overview:
Command scheduler between two draw requesters (0 = CPU register interface, 1 = copper/coprocessor) and one shared filled-rectangle engine. It arbitrates rectangle-fill commands round-robin and sequences the engine through start, run and done. It clips each emitted pixel and converts it to a VRAM word address. It issues one VRAM write per visible pixel, using a valid/ack handshake that back-pressures the engine.

Parameters:
CORDW, 16, signed coordinate width
ADDRW, 16, VRAM word address width
DATAW, 16, VRAM write data (fill colour) width

Ports:
clk  in  1  clock
reset_n_i  in  1  reset
req_valid_i  in  2  per-requester command valid
req_ready_o  out  2  one-cycle accept pulse, at most one bit set
req_x0_i, req_y0_i, req_x1_i, req_y1_i  in  2*CORDW each  packed per requester (requester n in bits [n*CORDW +: CORDW])
req_color_i  in  2*DATAW  packed fill colour
base_addr_i  in  ADDRW  bitmap base address
stride_i  in  ADDRW  words per line
clip_w_i, clip_h_i  in  CORDW  visible width/height
abort_i  in  1  abort current command
eng_start_o  out  1  engine start pulse
eng_x0_o, eng_y0_o, eng_x1_o, eng_y1_o  out  CORDW each  latched vertices to engine
eng_ena_o  out  1  engine advance enable
eng_abort_o  out  1  engine reset pulse
eng_pix_i  in  1  engine presents new pixel this cycle (only when eng_ena_o=1)
eng_x_i, eng_y_i  in  CORDW each  pixel coordinate
eng_done_i  in  1  engine finished (one cycle)
vram_wr_o  out  1  write request, held until ack
vram_addr_o  out  ADDRW  write address
vram_data_o  out  DATAW  write data
vram_ack_i  in  1  write accepted this cycle
busy_o  out  1  command in progress
done_o  out  1  one-cycle completion pulse
aborted_o  out  1  set with done_o when the command ended by abort, held until the next accept

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. clk with reset_n_i, asynchronous assert; all flops clear. Reset mid-command drops everything, including a pending VRAM write.
- Reset values: all outputs 0; state IDLE; last_grant = 1, so requester 0 wins the first tie.
- FSM states: IDLE, START, RUN, DRAIN.
- IDLE: if any req_valid_i is set, grant. With both set, grant the requester opposite last_grant. On grant: pulse req_ready_o[n], latch vertices, colour, base, stride, clip_w and clip_h; update last_grant; clear aborted_o; go to START.
- START: eng_start_o=1 for one cycle; busy_o=1 from START onward; go to RUN.
- RUN: on eng_done_i go to DRAIN.
- DRAIN: wait until stage1 and stage2 are empty, then pulse done_o, clear busy_o, go to IDLE. No new grant is made in the done_o cycle.
- Pixel pipeline stage1 (registered):
  - Loads on eng_pix_i.
  - vis = x>=0, y>=0, x<clip_w, y<clip_h (signed compare).
  - Computes prod = y*stride, low ADDRW bits.
  - Invisible pixels are carried with vis=0 and are never written.
- Pixel pipeline stage2:
  - vram_addr_o = base + prod + x, mod 2^ADDRW (wrap is legal, not an error).
  - vram_wr_o = stage1 valid AND vis.
  - vram_data_o = latched colour.
  - Outputs are held stable while vram_wr_o=1 and vram_ack_i=0.
- Back-pressure:
  - s2_free = !vram_wr_o | vram_ack_i.
  - s1_adv = !s1_valid | s2_free.
  - eng_ena_o = busy_o & (state==RUN) & s1_adv.
- Latency: pixel at cycle N gives vram_wr_o at N+2 with no stall. Sustained rate is 1 pixel/cycle with vram_ack_i held high.
- Abort (START or RUN):
  - Pulse eng_abort_o for one cycle and flush stage1.
  - A stage2 write already asserted still completes.
  - Go to DRAIN and set aborted_o.
- Abort in DRAIN: flush stage1 only. Abort in IDLE: ignored.
- eng_done_i and abort_i in the same cycle: abort wins.
- Degenerate rectangle (x0=x1, y0=y1): exactly one pixel.
- Requester valid with nothing accepted: the requester must hold its command; no queuing beyond the latch.

Decomposition:
- Shared package (draw_pkg): the FSM state enum, and a draw_cmd_t struct (x0, y0, x1, y1, color), reused by future line and blit schedulers.
- Sub-module draw_pix_addr holds pipeline stage1 and stage2: clip test, multiply, address add, VRAM handshake.
- Arbiter and FSM stay in the top module.

Test Plan:
- Req0 rect (2,1)-(4,2), base 0x1000, stride 80, clip 320x240, vram_ack_i=1 -> 6 writes, addresses 0x1052-0x1054 and 0x10A2-0x10A4, colour constant; one done_o pulse; aborted_o=0.
- Both requesters valid after reset, twice -> grants in order 0, 1, 0; req_ready_o pulses are one-hot.
- Rect (-1,0)-(1,0) with clip 320 -> writes only x=0,1; the x=-1 pixel is skipped but still consumed from the engine.
- vram_ack_i low for 5 cycles mid-rect -> eng_ena_o=0 after the pipeline fills; vram_addr_o and vram_data_o stable; no pixel lost or duplicated.
- abort_i during RUN while a write is pending -> that write completes; eng_abort_o pulses once; done_o=1 with aborted_o=1; no further writes.
- reset_n_i low mid-command -> all outputs 0 immediately (async); the next request is granted normally.
